prime_neighbor_search: RTL

PRIME_NEIGHBOR_SEARCH -- requirements
Module: prime_neighbor_search

---
 rtl/prime_pkg.sv | 21 ++
 rtl/prime_neighbor_search_if.sv | 26 ++
 rtl/prime_trial_unit.sv | 119 +++++++++++
 rtl/prime_neighbor_search.sv | 83 ++++++++
 4 files changed

// File: rtl/prime_pkg.sv
// Shared definitions for the prime neighbour search block: FSM states,
// engine direction and search constants.
package prime_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    DIR_UP  = 1'b0,
    DIR_LOW = 1'b1
  } dir_e;

  // First trial divisor for every new candidate.
  localparam int DIV_START = 2;
  // Widest supported operand; sizes the divisor register.
  localparam int W_MAX     = 16;

endpackage

// File: rtl/prime_neighbor_search_if.sv
// Request/response bundle for prime_neighbor_search. The master side issues
// a query N and takes the neighbouring primes; the slave side is the search.
interface prime_neighbor_search_if #(
  parameter int W = 14
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_n;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] up_prime;
  logic [W-1:0] low_prime;
  logic         up_none;
  logic         low_none;
  logic         busy;

  modport master (
    output in_valid, in_n, out_ready,
    input  in_ready, out_valid, up_prime, low_prime, up_none, low_none, busy
  );

  modport slave (
    input  in_valid, in_n, out_ready,
    output in_ready, out_valid, up_prime, low_prime, up_none, low_none, busy
  );
endinterface

// File: rtl/prime_trial_unit.sv
// One trial-division engine. Walks candidates away from N (up or down) and
// tests one divisor per cycle until a prime or the range edge is found.
// Build option: PRIME_SKIP_EVEN_EN -- odd divisors only after 2 and even
// candidates stepped over, giving the same answers in fewer cycles.
module prime_trial_unit
  import prime_pkg::*;
#(
  parameter int   W   = 14,
  parameter dir_e DIR = DIR_UP
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         run,
  input  logic [W-1:0] n,
  output logic         done,
  output logic         none,
  output logic [W-1:0] prime
);

`ifdef PRIME_SKIP_EVEN_EN
  localparam bit SKIP_EVEN = 1'b1;
`else
  localparam bit SKIP_EVEN = 1'b0;
`endif

  localparam int          DW    = W_MAX / 2 + 2;
  localparam int          XW    = 32;
  localparam logic [XW-1:0] LIMIT = XW'(1) << W;

  logic [W:0]    cand_reg, cand_next;
  logic [DW-1:0] div_reg, div_next, div_adv;
  logic          done_reg, done_next;
  logic          none_reg, none_next;
  logic [W-1:0]  prime_reg, prime_next;

  logic [XW-1:0] c_ext, d_ext, a_ext, sq, sq_adv, rem, step, moved;
  logic          c_neg, c_over, c_small, skip_two;

  // Arithmetic for the current (candidate, divisor) pair. The square of the
  // following divisor is also checked so a candidate is declared prime as
  // soon as its last needed divisor has been tried.
  always_comb begin
    c_ext    = XW'(cand_reg);
    d_ext    = XW'(div_reg);
    div_adv  = (SKIP_EVEN && div_reg != DW'(DIV_START)) ? div_reg + DW'(2) : div_reg + DW'(1);
    a_ext    = XW'(div_adv);
    sq       = d_ext * d_ext;
    sq_adv   = a_ext * a_ext;
    rem      = c_ext % d_ext;
    c_neg    = (DIR == DIR_LOW) && cand_reg[W];
    c_over   = (DIR == DIR_UP) && cand_reg[W];
    c_small  = c_neg || (cand_reg < (W+1)'(2));
    skip_two = SKIP_EVEN && cand_reg[0] && (cand_reg >= (W+1)'(3));
    step     = skip_two ? XW'(2) : XW'(1);
    moved    = (DIR == DIR_UP) ? c_ext + step : c_ext - step;
  end

  // Engine next state: load on start, search while running, hold once done.
  always_comb begin
    cand_next  = cand_reg;
    div_next   = div_reg;
    done_next  = done_reg;
    none_next  = none_reg;
    prime_next = prime_reg;
    if (start) begin
      cand_next  = (DIR == DIR_UP) ? {1'b0, n} + (W+1)'(1) : {1'b0, n} - (W+1)'(1);
      div_next   = DW'(DIV_START);
      done_next  = 1'b0;
      none_next  = 1'b0;
      prime_next = '0;
    end else if (run && !done_reg) begin
      if (c_over || (DIR == DIR_LOW && c_small)) begin
        done_next = 1'b1;
        none_next = 1'b1;
      end else if (!c_small && sq > c_ext) begin
        done_next  = 1'b1;
        prime_next = cand_reg[W-1:0];
      end else if (c_small || rem == '0) begin
        div_next = DW'(DIV_START);
        if (DIR == DIR_UP && moved >= LIMIT) begin
          done_next = 1'b1;
          none_next = 1'b1;
        end else begin
          cand_next = moved[W:0];
        end
      end else if (sq_adv > c_ext) begin
        done_next  = 1'b1;
        prime_next = cand_reg[W-1:0];
      end else begin
        div_next = div_adv;
      end
    end
  end

  // Engine state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_reg  <= '0;
      div_reg   <= DW'(DIV_START);
      done_reg  <= 1'b0;
      none_reg  <= 1'b0;
      prime_reg <= '0;
    end else begin
      cand_reg  <= cand_next;
      div_reg   <= div_next;
      done_reg  <= done_next;
      none_reg  <= none_next;
      prime_reg <= prime_next;
    end
  end

  // done reflects the cycle an engine concludes so the FSM can leave SEARCH
  // on the same edge the result is registered.
  assign done  = done_next;
  assign none  = none_reg;
  assign prime = prime_reg;

endmodule

// File: rtl/prime_neighbor_search.sv
// Finds the nearest primes above and below a query N with two trial-division
// engines running side by side, then holds the pair until it is taken.
// Build option: PRIME_SKIP_EVEN_EN (passed through to the engines).
module prime_neighbor_search
  import prime_pkg::*;
#(
  parameter int W = 14
) (
  input logic                     clk,
  input logic                     reset,
  prime_neighbor_search_if.slave  bus
);

  state_e       state_reg, state_next;
  logic         capture, run;
  logic         up_done, low_done;
  logic         up_none_w, low_none_w;
  logic [W-1:0] up_prime_w, low_prime_w;
  logic         in_ready_c, out_valid_c, busy_c;

  assign capture = (state_reg == IDLE) && bus.in_valid;
  assign run     = (state_reg == SEARCH);

  prime_trial_unit #(.W(W), .DIR(DIR_UP)) u_up (
    .clk   (clk),
    .reset (reset),
    .start (capture),
    .run   (run),
    .n     (bus.in_n),
    .done  (up_done),
    .none  (up_none_w),
    .prime (up_prime_w)
  );

  prime_trial_unit #(.W(W), .DIR(DIR_LOW)) u_low (
    .clk   (clk),
    .reset (reset),
    .start (capture),
    .run   (run),
    .n     (bus.in_n),
    .done  (low_done),
    .none  (low_none_w),
    .prime (low_prime_w)
  );

  // FSM state register; reset abandons any query in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // FSM transitions and handshake outputs.
  always_comb begin
    state_next  = state_reg;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_next = SEARCH;
      end
      SEARCH: begin
        busy_c = 1'b1;
        if (up_done && low_done) state_next = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.up_prime  = up_prime_w;
  assign bus.low_prime = low_prime_w;
  assign bus.up_none   = up_none_w;
  assign bus.low_none  = low_none_w;

endmodule
